// File: rtl/pc_ras_pkg.sv
// pc_pkg: op encodings shared by the pc_ras unit, its bus interface and its bench.
package pc_pkg;
  localparam int OP_W = 3;
  localparam logic [OP_W-1:0] OP_HOLD = 3'd0;
  localparam logic [OP_W-1:0] OP_INC  = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 3'd2;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd3;
  localparam logic [OP_W-1:0] OP_JMP  = 3'd4;
  localparam logic [OP_W-1:0] OP_CALL = 3'd5;
  localparam logic [OP_W-1:0] OP_RET  = 3'd6;
endpackage

// File: rtl/pc_ras_if.sv
// pc_ras_if: op/operand bus into the PC unit and the PC/RAS status coming back.
interface pc_ras_if #(parameter int WIDTH = 16, parameter int RAS_DEPTH = 4);
  import pc_pkg::*;
  localparam int CW = $clog2(RAS_DEPTH) + 1;
  logic en;
  logic [OP_W-1:0] op;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc;
  logic [CW-1:0] ras_count;
  logic ras_empty;
  logic ras_full;
  logic ras_ovf;
  logic ras_unf;
  modport master (output en, op, offset, target,
                  input pc, ras_count, ras_empty, ras_full, ras_ovf, ras_unf);
  modport slave (input en, op, offset, target,
                 output pc, ras_count, ras_empty, ras_full, ras_ovf, ras_unf);
endinterface

// File: rtl/pc_ras_stack.sv
// ras_stack: circular LIFO; a push while full overwrites the oldest entry.
module ras_stack #(
  parameter int WIDTH = 16,
  parameter int RAS_DEPTH = 4,
  localparam int PW = $clog2(RAS_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0] count,
  output logic full,
  output logic empty
);
  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0] sp;
  assign rdata = mem[sp - PW'(1)];
  assign empty = count == '0;
  assign full = count == CW'(RAS_DEPTH);
  always_ff @(posedge clk)
    if (push) mem[sp] <= wdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
      count <= '0;
    end else if (push) begin
      sp <= sp + PW'(1);
      count <= full ? count : count + CW'(1);
    end else if (pop && !empty) begin
      sp <= sp - PW'(1);
      count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/pc_ras.sv
// pc_ras: program counter with inc/add/sub/jump and call/return via a return-address stack.
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP = 1,
  parameter int RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input logic clk,
  input logic reset,
  pc_ras_if.slave bus
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;
  logic [WIDTH-1:0] pc_q, pc_d, pc_inc, rdata;
  logic [CW-1:0] count;
  logic full, empty, do_call, do_ret, ovf_q, unf_q;
  assign pc_inc = pc_q + WIDTH'(STEP);
  assign do_call = bus.en && bus.op == OP_CALL;
  assign do_ret = bus.en && bus.op == OP_RET;
  ras_stack #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_stack (
    .clk(clk), .reset(reset), .push(do_call && !reset), .pop(do_ret && !reset),
    .wdata(pc_inc), .rdata(rdata), .count(count), .full(full), .empty(empty)
  );
  // A return with nothing on the stack falls through like INC.
  always_comb begin
    pc_d = pc_q;
    if (bus.en)
      pc_d = bus.op == OP_INC ? pc_inc :
             bus.op == OP_ADD ? pc_q + bus.offset :
             bus.op == OP_SUB ? pc_q - bus.offset :
             (bus.op == OP_JMP || bus.op == OP_CALL) ? bus.target :
             bus.op == OP_RET ? (empty ? pc_inc : rdata) : pc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ovf_q <= ovf_q | (do_call && full);
      unf_q <= unf_q | (do_ret && empty);
    end
  end
  assign bus.pc = pc_q;
  assign bus.ras_count = count;
  assign bus.ras_empty = empty;
  assign bus.ras_full = full;
  assign bus.ras_ovf = ovf_q;
  assign bus.ras_unf = unf_q;
endmodule

// File: tb/tb_pc_ras.sv
// tb_pc_ras: directed vectors with a scoreboard queue checked by a negedge monitor.
module tb_pc_ras;
  import pc_pkg::*;
  typedef struct {
    logic [15:0] pc;
    logic [2:0] cnt;
    logic ovf;
    logic unf;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  pc_ras_if #(.WIDTH(16), .RAS_DEPTH(4)) bus ();
  pc_ras #(.WIDTH(16), .STEP(1), .RAS_DEPTH(4), .RESET_VEC(16'h0000)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  // The expectation for an op is queued right after the edge that samples it.
  task automatic step(input logic r, input logic e, input logic [2:0] o,
                      input logic [15:0] off, input logic [15:0] tgt,
                      input logic [15:0] ep, input logic [2:0] ec,
                      input logic eo, input logic eu);
    exp_t x;
    reset = r;
    bus.en = e;
    bus.op = o;
    bus.offset = off;
    bus.target = tgt;
    @(posedge clk);
    x.pc = ep;
    x.cnt = ec;
    x.ovf = eo;
    x.unf = eu;
    sb.push_back(x);
    #1;
  endtask
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t x;
      logic [3:0] ef, af;
      x = sb.pop_front();
      ef = {x.cnt == 3'd0, x.cnt == 3'd4, x.ovf, x.unf};
      af = {bus.ras_empty, bus.ras_full, bus.ras_ovf, bus.ras_unf};
      total += 3;
      if (bus.pc !== x.pc) begin
        bad++;
        $display("FAIL pc at %0t: got %h want %h", $time, bus.pc, x.pc);
      end
      if (bus.ras_count !== x.cnt) begin
        bad++;
        $display("FAIL ras_count at %0t: got %0d want %0d", $time, bus.ras_count, x.cnt);
      end
      if (af !== ef) begin
        bad++;
        $display("FAIL flags{empty,full,ovf,unf} at %0t: got %b want %b", $time, af, ef);
      end
    end
  end
  initial begin
    step(1, 0, OP_HOLD, 0, 0, 16'h0000, 0, 0, 0);
    step(0, 1, OP_INC, 0, 0, 16'h0001, 0, 0, 0);
    step(0, 1, OP_INC, 0, 0, 16'h0002, 0, 0, 0);
    step(0, 1, OP_INC, 0, 0, 16'h0003, 0, 0, 0);
    step(0, 1, OP_ADD, 16'h00A5, 0, 16'h00A8, 0, 0, 0);
    step(0, 1, OP_SUB, 16'h0014, 0, 16'h0094, 0, 0, 0);
    step(0, 1, OP_HOLD, 16'h1234, 16'h4321, 16'h0094, 0, 0, 0);
    step(0, 1, 3'd7, 16'h1234, 16'h4321, 16'h0094, 0, 0, 0);
    step(0, 1, OP_JMP, 0, 16'h0010, 16'h0010, 0, 0, 0);
    step(0, 1, OP_CALL, 0, 16'h0200, 16'h0200, 1, 0, 0);
    step(0, 1, OP_INC, 0, 0, 16'h0201, 1, 0, 0);
    step(0, 1, OP_RET, 0, 0, 16'h0011, 0, 0, 0);
    step(0, 1, OP_JMP, 0, 16'h0000, 16'h0000, 0, 0, 0);
    step(0, 1, OP_CALL, 0, 16'h0100, 16'h0100, 1, 0, 0);
    step(0, 1, OP_CALL, 0, 16'h0200, 16'h0200, 2, 0, 0);
    step(0, 1, OP_CALL, 0, 16'h0300, 16'h0300, 3, 0, 0);
    step(0, 1, OP_CALL, 0, 16'h0400, 16'h0400, 4, 0, 0);
    step(0, 1, OP_CALL, 0, 16'h0500, 16'h0500, 4, 1, 0);
    step(0, 1, OP_RET, 0, 0, 16'h0401, 3, 1, 0);
    step(0, 1, OP_RET, 0, 0, 16'h0301, 2, 1, 0);
    step(0, 1, OP_RET, 0, 0, 16'h0201, 1, 1, 0);
    step(0, 1, OP_RET, 0, 0, 16'h0101, 0, 1, 0);
    step(0, 1, OP_JMP, 0, 16'h0050, 16'h0050, 0, 1, 0);
    step(0, 1, OP_RET, 0, 0, 16'h0051, 0, 1, 1);
    step(0, 1, OP_INC, 0, 0, 16'h0052, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, OP_CALL, 0, 16'h0300, 16'h0052, 0, 1, 1);
    step(0, 0, OP_RET, 0, 0, 16'h0052, 0, 1, 1);
    step(0, 1, OP_CALL, 0, 16'h0300, 16'h0300, 1, 1, 1);
    step(0, 1, OP_JMP, 0, 16'hFFFF, 16'hFFFF, 1, 1, 1);
    step(0, 1, OP_INC, 0, 0, 16'h0000, 1, 1, 1);
    step(0, 1, OP_JMP, 0, 16'h0002, 16'h0002, 1, 1, 1);
    step(0, 1, OP_SUB, 16'h0005, 0, 16'hFFFD, 1, 1, 1);
    step(0, 1, OP_ADD, 16'h0010, 0, 16'h000D, 1, 1, 1);
    step(0, 1, OP_CALL, 0, 16'h0040, 16'h0040, 2, 1, 1);
    step(1, 1, OP_CALL, 0, 16'h0300, 16'h0000, 0, 0, 0);
    step(0, 1, OP_RET, 0, 0, 16'h0001, 0, 0, 1);
    step(1, 1, OP_RET, 0, 0, 16'h0000, 0, 0, 0);
    step(0, 1, OP_CALL, 0, 16'h0777, 16'h0777, 1, 0, 0);
    step(0, 1, OP_RET, 0, 0, 16'h0001, 0, 0, 0);
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_ras.md
Name: pc_ras

Overview:
- Parametrised program-counter unit with a built-in return-address stack (RAS).
- Supports increment, relative add/subtract, absolute jump, call (push return address + jump) and return (pop), with a stall enable.
- Sits at the front of the lab CPU datapath and feeds the instruction-memory address.
- Successor to the fixed 16-bit inc/add/sub PC: generalised width, step and stack depth, plus overflow/underflow reporting.

Parameters:
- WIDTH, 16, PC/offset/target width in bits.
- STEP, 1, increment amount for INC and for return-address computation.
- RAS_DEPTH, 4, number of RAS entries (power of two, ≥2).
- RESET_VEC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  1 = execute op this cycle; 0 = stall (all state holds).
- op  in  3  operation code (see Behaviour).
- offset  in  WIDTH  operand for ADD/SUB.
- target  in  WIDTH  absolute address for JMP/CALL.
- pc  out  WIDTH  current program counter (registered).
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries, 0..RAS_DEPTH.
- ras_empty  out  1  ras_count==0 (combinational from count).
- ras_full  out  1  ras_count==RAS_DEPTH.
- ras_ovf  out  1  sticky: a CALL occurred while full.
- ras_unf  out  1  sticky: a RET occurred while empty.

Behaviour:
- Reset: one clock, synchronous, active-high. Port names are clk and reset.
  - Reset is checked on the rising edge of clk only.
  - On reset: pc=RESET_VEC, ras_count=0, stack pointer=0, ras_ovf=0, ras_unf=0.
  - RAS entry contents are don't-care after reset.
- Priority: reset > en==0 (hold everything) > op.
- op encoding:
  - 0 HOLD: no change.
  - 1 INC: pc += STEP.
  - 2 ADD: pc += offset.
  - 3 SUB: pc -= offset.
  - 4 JMP: pc = target.
  - 5 CALL: push pc+STEP, then pc = target.
  - 6 RET: pc = top of stack, then pop.
  - 7: reserved, behaves as HOLD.
- Arithmetic: modulo 2^WIDTH, wrap silently, no carry/borrow output.
  - Example: 0xFFFF+STEP(1) → 0x0000.
  - Example: 0x0003 − 0x0005 → 0xFFFE.
- Latency: every op takes effect at the edge where it is sampled. New pc is visible one cycle after the op is presented.
- RAS is a circular LIFO indexed by the stack pointer.
  - CALL when not full: write at sp, sp+1, count+1.
  - CALL when full: write at sp (overwriting the oldest entry), sp+1 modulo RAS_DEPTH, count stays RAS_DEPTH, ras_ovf set to 1. The jump still happens.
  - RET when not empty: pc = entry[sp−1], sp−1, count−1.
  - RET when empty: pc = pc+STEP (treated as INC), sp and count unchanged, ras_unf set to 1.
- Sticky flags clear only on reset.
- A stalled op (en=0) has no side effects on the stack or flags.
- Reset asserted in the same cycle as CALL/RET: reset wins and no push/pop occurs.
- Operands offset/target are sampled only when the op uses them; their values are don't-care otherwise, X included.

Decomposition:
- Package pc_pkg:
  - op encodings as localparams: OP_HOLD, OP_INC, OP_ADD, OP_SUB, OP_JMP, OP_CALL, OP_RET.
  - op width constant = 3.
- Sub-module ras_stack (parameters WIDTH, RAS_DEPTH):
  - Inputs: push, pop, wdata.
  - Outputs: rdata (top of stack), count, full, empty.
  - Contains the circular overwrite-on-full rule.
- pc_ras holds the pc register, op decode and the sticky flags.

Test Plan (WIDTH=16, STEP=1, RAS_DEPTH=4, RESET_VEC=0):
- Reset, then INC ×3, ADD offset=0x00A5, SUB offset=0x0014 → pc: 0x0001, 0x0002, 0x0003, 0x00A8, 0x0094.
- pc=0x0010; CALL target=0x0200; INC; RET → pc 0x0200, 0x0201, 0x0011; ras_count 1→1→0; ras_empty=1 at end.
- CALL ×5 from pc 0x0000 to targets 0x100, 0x200, 0x300, 0x400, 0x500.
  - After the 5th CALL: ras_full=1, ras_ovf=1, ras_count=4.
  - RET ×4 → pc 0x0401, 0x0301, 0x0201, 0x0101; ras_empty=1.
- RET with empty stack at pc=0x0050 → pc=0x0051, ras_unf=1; a subsequent INC keeps ras_unf=1.
- en=0 with op=CALL target=0x0300 for 3 cycles → pc, ras_count and flags unchanged; then en=1 → pc=0x0300, ras_count+1.
- pc=0xFFFF, INC → 0x0000.
- pc=0x0002, SUB 0x0005 → 0xFFFD.
- Assert reset in the same cycle as CALL with ras_count=2 → pc=0x0000, ras_count=0, flags 0.
